// File: rtl/fme_pkg.sv
// Shared definitions for the FME residual path: block geometry, residual width and sample/vector types.
package fme_pkg;

    localparam int BLOCK_DIM         = 8;
    localparam int DATAWIDTH_DEFAULT = 8;

    function automatic int RES_W(input int datawidth);
        return datawidth + 1;
    endfunction

    localparam int RES_W_DEFAULT = RES_W(DATAWIDTH_DEFAULT);

    typedef logic signed [RES_W_DEFAULT-1:0] residual_t;
    typedef residual_t [BLOCK_DIM-1:0]       res_vec_t;

endpackage

// File: rtl/residual_bank.sv
// One 8x8 residual bank: row-wide write port, column-wide read mux.
// With RESIDUAL_ZERO_FLAG_EN defined it also tracks whether any written sample was nonzero.
module residual_bank
    import fme_pkg::*;
#(
    parameter int RW = 9
) (
    input  logic                          clock,
    input  logic                          wr_en_i,
    input  logic [2:0]                    wr_row_i,
    input  logic [BLOCK_DIM-1:0][RW-1:0]  wr_data_i,
    input  logic [2:0]                    rd_col_i,
`ifdef RESIDUAL_ZERO_FLAG_EN
    output logic                          nz_o,
`endif
    output logic [BLOCK_DIM-1:0][RW-1:0]  rd_data_o
);

    // Indexed [row][col]; contents are deliberately left unreset.
    logic [BLOCK_DIM-1:0][BLOCK_DIM-1:0][RW-1:0] mem_q;

    // Row write into storage.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_row_i] <= wr_data_i;
        end else begin
            mem_q <= mem_q;
        end
    end

    // Column read: element k of the output is row k at the selected column.
    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < BLOCK_DIM; k++) begin
            rd_data_o[k] = mem_q[k][rd_col_i];
        end
    end

`ifdef RESIDUAL_ZERO_FLAG_EN
    logic nz_q;

    // Row 0 restarts the flag; later rows accumulate into it.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            nz_q <= (|wr_data_i) | ((wr_row_i != 3'd0) & nz_q);
        end else begin
            nz_q <= nz_q;
        end
    end

    assign nz_o = nz_q;
`endif

endmodule

// File: rtl/residual_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer: accepts residual rows, re-emits each block column by column.
// Optional RESIDUAL_ZERO_FLAG_EN adds the zero_block output.
module residual_transpose_buffer
    import fme_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH:0]   in_0,
    input  logic [DATAWIDTH:0]   in_1,
    input  logic [DATAWIDTH:0]   in_2,
    input  logic [DATAWIDTH:0]   in_3,
    input  logic [DATAWIDTH:0]   in_4,
    input  logic [DATAWIDTH:0]   in_5,
    input  logic [DATAWIDTH:0]   in_6,
    input  logic [DATAWIDTH:0]   in_7,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
`ifdef RESIDUAL_ZERO_FLAG_EN
    output logic                 zero_block,
`endif
    output logic [DATAWIDTH:0]   out_0,
    output logic [DATAWIDTH:0]   out_1,
    output logic [DATAWIDTH:0]   out_2,
    output logic [DATAWIDTH:0]   out_3,
    output logic [DATAWIDTH:0]   out_4,
    output logic [DATAWIDTH:0]   out_5,
    output logic [DATAWIDTH:0]   out_6,
    output logic [DATAWIDTH:0]   out_7
);

    localparam int RW = RES_W(DATAWIDTH);

    logic [1:0] full_q, full_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [2:0] wr_row_q, wr_row_d;
    logic [2:0] rd_col_q, rd_col_d;

    logic                          wr_fire_s;
    logic                          rd_fire_s;
    logic [1:0]                    bank_we_s;
    logic [BLOCK_DIM-1:0][RW-1:0]  row_s;
    logic [BLOCK_DIM-1:0][RW-1:0]  rd_data_s [2];
    logic [BLOCK_DIM-1:0][RW-1:0]  col_s;
`ifdef RESIDUAL_ZERO_FLAG_EN
    logic [1:0]                    nz_s;
`endif

    assign row_s     = {in_7, in_6, in_5, in_4, in_3, in_2, in_1, in_0};
    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign out_last  = out_valid && (rd_col_q == 3'd7);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we_s[b] = wr_fire_s && (wr_bank_q == 1'(b));

        residual_bank #(.RW(RW)) u_bank (
            .clock     (clock),
            .wr_en_i   (bank_we_s[b]),
            .wr_row_i  (wr_row_q),
            .wr_data_i (row_s),
            .rd_col_i  (rd_col_q),
`ifdef RESIDUAL_ZERO_FLAG_EN
            .nz_o      (nz_s[b]),
`endif
            .rd_data_o (rd_data_s[b])
        );
    end

`ifdef RESIDUAL_ZERO_FLAG_EN
    assign zero_block = out_valid && !nz_s[rd_bank_q];
`endif

    // Output column, forced to zero while nothing is being presented.
    always_comb begin
        col_s = '0;
        if (out_valid) begin
            col_s = rd_data_s[rd_bank_q];
        end else begin
            col_s = '0;
        end
    end

    assign out_0 = col_s[0];
    assign out_1 = col_s[1];
    assign out_2 = col_s[2];
    assign out_3 = col_s[3];
    assign out_4 = col_s[4];
    assign out_5 = col_s[5];
    assign out_6 = col_s[6];
    assign out_7 = col_s[7];

    // Pointer and flag next-state; a write can only hit an empty bank and a read a full one,
    // so the set and clear below never touch the same bank.
    always_comb begin
        wr_fire_s = in_valid && in_ready;
        rd_fire_s = out_valid && out_ready;
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_row_d  = wr_row_q;
        rd_col_d  = rd_col_q;
        if (wr_fire_s) begin
            wr_row_d = wr_row_q + 3'd1;
            if (wr_row_q == 3'd7) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end else begin
                wr_bank_d = wr_bank_q;
            end
        end else begin
            wr_row_d = wr_row_q;
        end
        if (rd_fire_s) begin
            rd_col_d = rd_col_q + 3'd1;
            if (rd_col_q == 3'd7) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end else begin
                rd_bank_d = rd_bank_q;
            end
        end else begin
            rd_col_d = rd_col_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q  <= 3'd0;
            rd_col_q  <= 3'd0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_row_q  <= wr_row_d;
            rd_col_q  <= rd_col_d;
        end
    end

endmodule
